// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg -- shared AES key-schedule types, constants and helpers. Rev 1.0
// ============================================================================
package aes_pkg;

  localparam int WORD_W = 32;
  localparam int RK_W   = 128;
  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } ks_state_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

endpackage

`default_nettype wire

// File: rtl/aes_sbox.sv
`default_nettype none
// ============================================================================
// aes_sbox -- combinational AES forward S-box (one byte). Rev 1.0
// ============================================================================
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry 0x00 sits in the MSBs, so byte b lives at bit offset 8*(255-b) = 8*~b.
  localparam logic [2047:0] C_SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_bit_idx;

  assign w_bit_idx = {~i_byte, 3'b000};
  assign o_byte    = C_SBOX[w_bit_idx +: 8];

endmodule

`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// aes_key_sched_ctrl -- iterative AES key expansion (one word/clock) and
// registered round-key server. Rev 1.0
// ============================================================================
module aes_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [NK*32-1:0] key_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic             done_o,
  input  logic             rk_req_i,
  input  logic [3:0]       rk_round_i,
  output logic             rk_valid_o,
  output logic             rk_err_o,
  output logic [127:0]     rk_data_o
);

  localparam int NR = nr_of(NK);
  localparam int NW = 4 * (NR + 1);

  ks_state_t         r_state, w_state_nx;
  logic              w_load, w_done_nx;
  logic [5:0]        r_idx;
  logic [2:0]        r_ph;
  logic [7:0]        r_rcon;
  logic              r_done;
  logic [WORD_W-1:0] r_w [NW];

  logic [WORD_W-1:0] w_prev, w_old, w_sub_in, w_sub, w_t, w_new;

  logic              r_rk_valid, r_rk_err;
  logic [RK_W-1:0]   r_rk_data;
  logic [5:0]        w_base;

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_done_nx  = 1'b0;
    case (r_state)
      ST_IDLE, ST_READY: begin
        if (start_i) begin
          w_load     = 1'b1;
          w_state_nx = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        if (r_idx == 6'(NW - 1)) begin
          w_state_nx = ST_READY;
          w_done_nx  = 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_ph    <= '0;
      r_rcon  <= RCON_INIT;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_done  <= w_done_nx;
      if (w_load) begin
        r_idx  <= 6'(NK);
        r_ph   <= '0;
        r_rcon <= RCON_INIT;
      end else if (r_state == ST_EXPAND) begin
        r_idx <= r_idx + 6'd1;
        r_ph  <= (r_ph == 3'(NK - 1)) ? 3'd0 : r_ph + 3'd1;
        if (r_ph == 3'd0) r_rcon <= xtime(r_rcon);
      end
    end
  end

  // One SubWord unit: fed RotWord(w[i-1]) at phase 0, else w[i-1] itself.
  assign w_prev   = r_w[r_idx - 6'd1];
  assign w_old    = r_w[r_idx - 6'(NK)];
  assign w_sub_in = (r_ph == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (w_sub_in[g*8 +: 8]),
      .o_byte (w_sub[g*8 +: 8])
    );
  end

  always_comb begin
    w_t = w_prev;
    if (r_ph == 3'd0)                w_t = w_sub ^ {r_rcon, 24'h0};
    else if (NK == 8 && r_ph == 3'd4) w_t = w_sub;
  end

  assign w_new = w_old ^ w_t;

  always_ff @(posedge clk) begin
    if (w_load) begin
      for (int k = 0; k < NK; k++) r_w[k] <= key_i[(NK-1-k)*32 +: 32];
    end else if (r_state == ST_EXPAND) begin
      r_w[r_idx] <= w_new;
    end
  end

  // Response samples the store before any same-edge reload, so it sees the old set.
  assign w_base = {rk_round_i, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rk_valid <= 1'b0;
      r_rk_err   <= 1'b0;
      r_rk_data  <= '0;
    end else begin
      r_rk_valid <= rk_req_i;
      r_rk_err   <= 1'b0;
      r_rk_data  <= '0;
      if (rk_req_i) begin
        if (r_state == ST_READY && rk_round_i <= 4'(NR)) begin
          r_rk_data <= {r_w[w_base], r_w[w_base + 6'd1],
                        r_w[w_base + 6'd2], r_w[w_base + 6'd3]};
        end else begin
          r_rk_err <= 1'b1;
        end
      end
    end
  end

  assign busy_o     = (r_state == ST_EXPAND);
  assign ready_o    = (r_state == ST_READY);
  assign done_o     = r_done;
  assign rk_valid_o = r_rk_valid;
  assign rk_err_o   = r_rk_err;
  assign rk_data_o  = r_rk_data;

endmodule

`default_nettype wire

// File: tb/tb_aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
// tb_aes_key_sched_ctrl -- directed bench for AES-128/192/256 key schedules.
// ============================================================================
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   start, req;
  logic [2:0]   busy, ready, done, valid, err;
  logic [3:0]   rnd  [3];
  logic [127:0] data [3];
  logic [127:0] k128;
  logic [191:0] k192;
  logic [255:0] k256;
  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [127:0] K128_A   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R10_A    = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R1_A     = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K128_B   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] R10_B    = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  always #5 clk = ~clk;

  aes_key_sched_ctrl #(.NK(4)) u_dut128 (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .key_i(k128),
    .busy_o(busy[0]), .ready_o(ready[0]), .done_o(done[0]),
    .rk_req_i(req[0]), .rk_round_i(rnd[0]), .rk_valid_o(valid[0]),
    .rk_err_o(err[0]), .rk_data_o(data[0]));

  aes_key_sched_ctrl #(.NK(6)) u_dut192 (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .key_i(k192),
    .busy_o(busy[1]), .ready_o(ready[1]), .done_o(done[1]),
    .rk_req_i(req[1]), .rk_round_i(rnd[1]), .rk_valid_o(valid[1]),
    .rk_err_o(err[1]), .rk_data_o(data[1]));

  aes_key_sched_ctrl #(.NK(8)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .start_i(start[2]), .key_i(k256),
    .busy_o(busy[2]), .ready_o(ready[2]), .done_o(done[2]),
    .rk_req_i(req[2]), .rk_round_i(rnd[2]), .rk_valid_o(valid[2]),
    .rk_err_o(err[2]), .rk_data_o(data[2]));

  typedef struct {
    int           s;
    logic [3:0]   r;
    logic         e;
    logic [127:0] d;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check(name, {127'b0, act}, {127'b0, exp});
  endtask

  task automatic read(input int s, input logic [3:0] r, input logic e,
                      input logic [127:0] d, input string name);
    req[s] = 1'b1;
    rnd[s] = r;
    tick();
    req[s] = 1'b0;
    check1({name, "_valid"}, valid[s], 1'b1);
    check1({name, "_err"}, err[s], e);
    check({name, "_data"}, data[s], d);
  endtask

  // Start an expansion and count edges until done_o; optionally disturb it with
  // a second start (different key) and an early read.
  task automatic expand(input int s, input int exp_edges, input bit disturb);
    int edges;
    edges = 0;
    start[s] = 1'b1;
    while (done[s] !== 1'b1 && edges < 100) begin
      tick();
      edges++;
      start[s] = disturb && (edges == 10);
      if (disturb && edges == 10) k128 = '1;
      if (edges == 1) begin
        check1("busy_rise", busy[s], 1'b1);
        check1("ready_fall", ready[s], 1'b0);
      end
      if (disturb) begin
        req[s] = (edges == 20);
        rnd[s] = 4'd1;
        if (edges == 21) begin
          check1("expand_rd_valid", valid[s], 1'b1);
          check1("expand_rd_err", err[s], 1'b1);
          check("expand_rd_data", data[s], 128'h0);
        end
      end
    end
    check("done_latency", 128'(edges), 128'(exp_edges));
    check1("ready_at_done", ready[s], 1'b1);
    check1("busy_at_done", busy[s], 1'b0);
    tick();
    check1("done_pulse_width", done[s], 1'b0);
  endtask

  initial begin
    int edges;
    start = '0;
    req   = '0;
    for (int i = 0; i < 3; i++) rnd[i] = '0;
    k128 = K128_A;
    k192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    vecs[0]  = '{0, 4'd0,  1'b0, K128_A};
    vecs[1]  = '{0, 4'd1,  1'b0, R1_A};
    vecs[2]  = '{0, 4'd2,  1'b0, 128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3]  = '{0, 4'd10, 1'b0, R10_A};
    vecs[4]  = '{0, 4'd11, 1'b1, 128'h0};
    vecs[5]  = '{0, 4'd15, 1'b1, 128'h0};
    vecs[6]  = '{1, 4'd0,  1'b0, 128'h8e73b0f7da0e6452c810f32b809079e5};
    vecs[7]  = '{1, 4'd12, 1'b0, 128'he98ba06f448c773c8ecc720401002202};
    vecs[8]  = '{1, 4'd13, 1'b1, 128'h0};
    vecs[9]  = '{2, 4'd0,  1'b0, 128'h603deb1015ca71be2b73aef0857d7781};
    vecs[10] = '{2, 4'd1,  1'b0, 128'h1f352c073b6108d72d9810a30914dff4};
    vecs[11] = '{2, 4'd14, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e};
    vecs[12] = '{2, 4'd15, 1'b1, 128'h0};

    tick();
    tick();
    check1("rst_busy", busy[0], 1'b0);
    check1("rst_ready", ready[0], 1'b0);
    check1("rst_done", done[0], 1'b0);
    check1("rst_valid", valid[0], 1'b0);
    check1("rst_err", err[0], 1'b0);
    check("rst_data", data[0], 128'h0);
    rst_n = 1'b1;
    tick();

    read(0, 4'd1, 1'b1, 128'h0, "read_unready");

    expand(0, 41, 1'b1);
    expand(1, 47, 1'b0);
    expand(2, 53, 1'b0);

    // Back-to-back reads, one request per cycle.
    for (int i = 0; i < 13; i++)
      read(vecs[i].s, vecs[i].r, vecs[i].e, vecs[i].d, $sformatf("vec%0d", i));
    tick();
    check1("valid_idle", valid[0], 1'b0);

    // Restart in READY with a same-edge read: old key set is returned.
    k128     = K128_B;
    start[0] = 1'b1;
    req[0]   = 1'b1;
    rnd[0]   = 4'd10;
    tick();
    start[0] = 1'b0;
    check1("restart_rd_valid", valid[0], 1'b1);
    check1("restart_rd_err", err[0], 1'b0);
    check("restart_rd_data", data[0], R10_A);
    tick();
    req[0] = 1'b0;
    check1("restart_next_err", err[0], 1'b1);
    check("restart_next_data", data[0], 128'h0);
    edges = 2;
    while (done[0] !== 1'b1 && edges < 100) begin
      tick();
      edges++;
    end
    check("restart_done_latency", 128'(edges), 128'd41);
    read(0, 4'd10, 1'b0, R10_B, "new_r10");
    read(0, 4'd0, 1'b0, K128_B, "new_r0");

    // Reset asserted mid-expansion.
    k128     = K128_A;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    repeat (19) tick();
    check1("pre_rst_busy", busy[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check1("midrst_busy", busy[0], 1'b0);
    check1("midrst_ready", ready[0], 1'b0);
    check1("midrst_ready256", ready[2], 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    read(0, 4'd10, 1'b1, 128'h0, "read_after_rst");
    expand(0, 41, 1'b0);
    read(0, 4'd10, 1'b0, R10_A, "post_rst_r10");
    read(0, 4'd1, 1'b0, R1_A, "post_rst_r1");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
